// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   // Access sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DONE  = 2'd2,
      ST_FAULT = 2'd3
   } lsu_state_t;

   // RV32I funct3 size/sign encodings for loads and stores.
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   // Cycles from mem_req to mem_ack before the access is abandoned.
   localparam int LSU_DEFAULT_TIMEOUT = 15;

   // A request is legal when funct3 is a known size, the address is
   // naturally aligned for that size, and a store does not use an
   // unsigned (funct3[2]=1) encoding.
   function automatic logic lsu_req_legal(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
      logic ok;
      case (funct3)
         LB, LBU: ok = 1'b1;
         LH, LHU: ok = ~addr_lo[0];
         LW:      ok = (addr_lo == 2'b00);
         default: ok = 1'b0;
      endcase
      if (we && funct3[2]) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword lane out of a read word and
// sign- or zero-extends it to 32 bits.
module load_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   output logic [31:0] data
);

   logic        [7:0]  lane_b;
   logic        [15:0] lane_h;
   logic signed [7:0]  lane_b_s;
   logic signed [15:0] lane_h_s;

   // Lane selection followed by extension chosen by funct3.
   always_comb begin
      lane_b   = word[{addr_lo, 3'b000} +: 8];
      lane_h   = addr_lo[1] ? word[31:16] : word[15:0];
      lane_b_s = signed'(lane_b);
      lane_h_s = signed'(lane_h);
      data     = word;
      case (funct3)
         LB:      data = 32'(lane_b_s);
         LBU:     data = {24'd0, lane_b};
         LH:      data = 32'(lane_h_s);
         LHU:     data = {16'd0, lane_h};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between an RV32I core and a
// request/acknowledge memory port, with alignment checks and timeout.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = LSU_DEFAULT_TIMEOUT
)
(
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              done,
   output logic              fault,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   localparam logic [3:0] TMO = 4'(TIMEOUT);

   lsu_state_t  state;
   logic        cap_we;
   logic [2:0]  cap_f3;
   logic [1:0]  cap_lo;
   logic [3:0]  tmo_cnt;

   logic        req_ok;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [31:0] load_data;

   assign req_ok = lsu_req_legal(req_we, req_funct3, req_addr[1:0]);

   // The core is held while a request is being presented or is in flight.
   assign stall = RESET_N & (((state == ST_IDLE) & req_valid) | (state == ST_BUSY));

   // Byte enables and lane-replicated store data for the incoming request.
   always_comb begin
      be_next    = 4'b1111;
      wdata_next = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            be_next    = 4'b0001 << req_addr[1:0];
            wdata_next = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be_next    = 4'b0011 << req_addr[1:0];
            wdata_next = {2{req_wdata[15:0]}};
         end
         default: begin
            be_next    = 4'b1111;
            wdata_next = req_wdata;
         end
      endcase
   end

   load_align u_align (
      .word    (mem_rdata),
      .funct3  (cap_f3),
      .addr_lo (cap_lo),
      .data    (load_data)
   );

   // Access FSM with timeout counter and registered memory-side outputs.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= ST_IDLE;
         cap_we    <= 1'b0;
         cap_f3    <= 3'b000;
         cap_lo    <= 2'b00;
         tmo_cnt   <= 4'd0;
         rdata     <= 32'd0;
         done      <= 1'b0;
         fault     <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= 4'b0000;
         mem_wdata <= 32'd0;
      end else begin
         done  <= 1'b0;
         fault <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  if (req_ok) begin
                     state     <= ST_BUSY;
                     cap_we    <= req_we;
                     cap_f3    <= req_funct3;
                     cap_lo    <= req_addr[1:0];
                     tmo_cnt   <= 4'd0;
                     mem_req   <= 1'b1;
                     mem_we    <= req_we;
                     mem_be    <= be_next;
                     mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                     mem_wdata <= wdata_next;
                  end else begin
                     state <= ST_FAULT;
                     fault <= 1'b1;
                  end
               end
            end
            ST_BUSY: begin
               if (mem_ack) begin
                  state   <= ST_DONE;
                  done    <= 1'b1;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  mem_be  <= 4'b0000;
                  if (!cap_we) rdata <= load_data;
               end else if ((tmo_cnt + 4'd1) == TMO) begin
                  state   <= ST_FAULT;
                  fault   <= 1'b1;
                  tmo_cnt <= tmo_cnt + 4'd1;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  mem_be  <= 4'b0000;
               end else begin
                  tmo_cnt <= tmo_cnt + 4'd1;
               end
            end
            ST_DONE:  state <= ST_IDLE;
            ST_FAULT: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected results are queued when a
// request is driven and checked when done/fault pulses.
module tb_load_store_unit;

   localparam int TMO = 15;

   logic        CLK;
   logic        RESET_N;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic [31:0] rdata;
   logic        done;
   logic        fault;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   typedef struct {
      logic        fault;
      logic [31:0] rdata;
      logic [31:0] maddr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      int          req_cycles;
      int          req_cyc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          fails = 0;
   int          cyc = 0;
   int          busy_cnt = 0;
   int          pulses = 0;
   bit          completed = 0;
   logic [31:0] mdl_rdata = 32'd0;

   load_store_unit #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .rdata      (rdata),
      .done       (done),
      .fault      (fault),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model of one access, written from the byte-lane view.
   task automatic build_exp(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] word,
                            input int ack_at, output exp_t e);
      int          nb;
      int          lo;
      logic        legal;
      logic [31:0] ld;
      lo    = int'(addr[1:0]);
      nb    = 1 << f3[1:0];
      legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101)
              && !(we && f3[2]) && (lo % nb == 0);
      e.maddr = {addr[31:2], 2'b00};
      e.we    = we;
      e.be    = 4'b0000;
      e.wdata = 32'd0;
      ld      = 32'd0;
      if (legal) begin
         for (int i = 0; i < 4; i++) begin
            if (i >= lo && i < lo + nb) e.be[i] = 1'b1;
            e.wdata[8*i +: 8] = wdata[8*(i % nb) +: 8];
         end
         for (int i = 0; i < nb; i++) ld[8*i +: 8] = word[8*(lo + i) +: 8];
         if (!f3[2] && nb < 4 && ld[8*nb-1])
            for (int i = nb; i < 4; i++) ld[8*i +: 8] = 8'hFF;
      end
      if (!legal) begin
         e.fault = 1'b1; e.req_cycles = 0;
      end else if (ack_at < 1 || ack_at > TMO) begin
         e.fault = 1'b1; e.req_cycles = TMO;
      end else begin
         e.fault = 1'b0; e.req_cycles = ack_at;
         if (!we) mdl_rdata = ld;
      end
      e.rdata   = mdl_rdata;
      e.req_cyc = 0;
   endtask

   // Monitor: checks the memory side every busy cycle and scores completions.
   always @(negedge CLK) begin : mon
      exp_t e;
      if (RESET_N) begin
         if (mem_req) begin
            busy_cnt++;
            if (sb.size() == 0) chk("mem_req_unexpected", 32'(mem_req), 32'd0);
            else begin
               if (sb[0].req_cycles == 0) chk("no_mem_req_on_fault", 32'(mem_req), 32'd0);
               chk("mem_addr", mem_addr, sb[0].maddr);
               chk("mem_be", 32'(mem_be), 32'(sb[0].be));
               chk("mem_we", 32'(mem_we), 32'(sb[0].we));
               if (sb[0].we) chk("mem_wdata", mem_wdata, sb[0].wdata);
               chk("stall_busy", 32'(stall), 32'd1);
            end
         end
         if (done || fault) begin
            pulses++;
            if (sb.size() == 0) chk("spurious_pulse", {30'd0, done, fault}, 32'd0);
            else begin
               e = sb.pop_front();
               chk("fault", 32'(fault), 32'(e.fault));
               chk("done", 32'(done), 32'(!e.fault));
               chk("rdata", rdata, e.rdata);
               chk("req_cycles", 32'(busy_cnt), 32'(e.req_cycles));
               chk("latency", 32'(cyc - e.req_cyc), 32'(e.req_cycles + 1));
               chk("stall_end", 32'(stall), 32'd0);
               chk("mem_req_end", 32'(mem_req), 32'd0);
            end
            busy_cnt  = 0;
            completed = 1'b1;
         end
      end
   end

   task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] word, input int ack_at);
      exp_t e;
      int   n;
      bit   fin;
      build_exp(we, f3, addr, wdata, word, ack_at, e);
      @(posedge CLK); #1;
      completed  = 1'b0;
      e.req_cyc  = cyc;
      sb.push_back(e);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      mem_rdata  = word;
      #1 chk("stall_req", 32'(stall), 32'd1);
      @(posedge CLK); #1;
      req_valid = 1'b0;
      n   = 0;
      fin = 0;
      while (!fin && n < 40) begin
         n++;
         mem_ack = mem_req && (n == ack_at);
         @(posedge CLK); #1;
         mem_ack = 1'b0;
         if (completed) fin = 1;
      end
      if (!fin) begin
         chk("completion_bound", 32'd0, 32'd1);
         sb.delete();
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin : stim
      int pulses_snap;
      logic [2:0] f3_tab [5];
      logic [2:0] f3;
      logic       we;
      f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
      f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;
      RESET_N = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
      #12;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      chk("idle_stall", 32'(stall), 32'd0);

      access(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 1);   // LW
      access(1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF0000, 1);   // LB
      access(1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF0000, 1);   // LBU
      access(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'd0, 2);   // SH
      access(1'b0, 3'b010, 32'h101, 32'd0, 32'h12345678, 1);   // LW misaligned
      access(1'b0, 3'b010, 32'h200, 32'd0, 32'h11111111, 0);   // LW timeout
      access(1'b0, 3'b010, 32'h204, 32'd0, 32'h22222222, TMO); // LW ack on last cycle
      access(1'b0, 3'b001, 32'h302, 32'd0, 32'h80011234, 1);   // LH upper
      access(1'b0, 3'b101, 32'h300, 32'd0, 32'h80019234, 3);   // LHU lower
      access(1'b1, 3'b000, 32'h401, 32'h0000005A, 32'd0, 3);   // SB
      access(1'b1, 3'b010, 32'h404, 32'hCAFEF00D, 32'd0, 1);   // SW
      access(1'b0, 3'b011, 32'h408, 32'd0, 32'd0, 1);          // illegal funct3
      access(1'b1, 3'b100, 32'h408, 32'h77, 32'd0, 1);         // store with funct3[2]=1
      access(1'b0, 3'b001, 32'h403, 32'd0, 32'd0, 1);          // LH misaligned

      // Acks while idle must be ignored.
      for (int i = 0; i < 3; i++) begin
         mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
         @(posedge CLK); #1;
         chk("idle_ack_done", 32'(done), 32'd0);
      end
      mem_ack = 1'b0;
      chk("idle_ack_rdata", rdata, mdl_rdata);

      for (int k = 0; k < 12; k++) begin
         f3 = f3_tab[$urandom_range(0, 4)];
         we = (f3[2] == 1'b0) ? 1'($urandom_range(0, 1)) : 1'b0;
         access(we, f3, 32'h600 + 32'($urandom_range(0, 63)), $urandom, $urandom,
                int'($urandom_range(1, 4)));
      end

      // Reset while an access is in flight.
      begin : mid_reset
         exp_t e;
         build_exp(1'b0, 3'b010, 32'h500, 32'd0, 32'd0, 0, e);
         @(posedge CLK); #1;
         e.req_cyc = cyc;
         sb.push_back(e);
         req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500;
         @(posedge CLK); #1;
         req_valid = 1'b0;
         repeat (3) @(posedge CLK);
         #3;
         RESET_N = 1'b0;
         #1;
         chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
         chk("mid_rst_stall", 32'(stall), 32'd0);
         chk("mid_rst_mem_be", 32'(mem_be), 32'd0);
         chk("mid_rst_mem_addr", mem_addr, 32'd0);
         chk("mid_rst_rdata", rdata, 32'd0);
         chk("mid_rst_done_fault", {30'd0, done, fault}, 32'd0);
         sb.delete();
         busy_cnt  = 0;
         mdl_rdata = 32'd0;
         @(posedge CLK); #1;
         RESET_N = 1'b1;
         pulses_snap = pulses;
         repeat (TMO + 5) @(posedge CLK);
         #1 chk("no_pulse_after_reset", 32'(pulses - pulses_snap), 32'd0);
      end

      access(1'b0, 3'b000, 32'h700, 32'd0, 32'h0000007F, 1);   // recovery LB
      repeat (2) @(posedge CLK);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
